// File: rtl/brc_pkg.sv
// rtl/brc_pkg.sv - shared types and decode function for the brc_pipe branch-resolution unit
package brc_pkg;

  // Upper bound on the sideband tag width carried through stage 1 (TAG_W must not exceed it)
  localparam int BRC_TAG_W_MAX = 16;

  // RV32I branch funct3 encodings; 010 and 011 are reserved and decode as illegal
  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_op_e;

  // Everything stage 2 needs to resolve a branch without revisiting the operands
  typedef struct packed {
    logic                     eq;
    logic                     lt_s;
    logic                     lt_u;
    br_op_e                   op;
    logic                     pred;
    logic [BRC_TAG_W_MAX-1:0] tag;
  } brc_s1_t;

  // Returns {taken, illegal}; reserved encodings resolve not-taken and illegal
  function automatic logic [1:0] br_taken(input br_op_e op, input logic eq,
                                          input logic lt_s, input logic lt_u);
    logic taken;
    logic illegal;
    taken   = 1'b0;
    illegal = 1'b0;
    case (op)
      BR_EQ:   taken = eq;
      BR_NE:   taken = ~eq;
      BR_LT:   taken = lt_s;
      BR_GE:   taken = ~lt_s;
      BR_LTU:  taken = lt_u;
      BR_GEU:  taken = ~lt_u;
      default: illegal = 1'b1;
    endcase
    return {taken, illegal};
  endfunction

endpackage

// File: rtl/brc_cmp.sv
// rtl/brc_cmp.sv - combinational subtract-based operand compare (eq, signed lt, unsigned lt)
module brc_cmp
  import brc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_eq,
  output logic              o_lt_s,
  output logic              o_lt_u
);

  logic [DATA_W:0] diff;
  logic            ovf;

  // A-B formed as A + ~B + 1 on one adder; carry-out low means a borrow, i.e. A < B unsigned
  always_comb begin
    diff   = {1'b0, i_a} + {1'b0, ~i_b} + {{DATA_W{1'b0}}, 1'b1};
    ovf    = (i_a[DATA_W-1] ^ i_b[DATA_W-1]) & (diff[DATA_W-1] ^ i_a[DATA_W-1]);
    o_eq   = (i_a == i_b);
    o_lt_s = diff[DATA_W-1] ^ ovf;
    o_lt_u = ~diff[DATA_W];
  end

endmodule

// File: rtl/brc_pipe.sv
// rtl/brc_pipe.sv - two-stage branch resolution with valid/ready, flush, mispredict flag; optional counters under BRC_PERF_CNT_EN
module brc_pipe
  import brc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [DATA_W-1:0] i_rs2_data,
  input  logic [2:0]        i_funct3,
  input  logic              i_pred_taken,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_taken,
  output logic              o_mispredict,
  output logic              o_illegal,
  output logic [TAG_W-1:0]  o_tag,
  input  logic              i_cnt_clr,
  output logic [CNT_W-1:0]  o_br_cnt,
  output logic [CNT_W-1:0]  o_misp_cnt
);

  logic             cmp_eq;
  logic             cmp_lt_s;
  logic             cmp_lt_u;
  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic [1:0]       res;

  logic             s1_valid_d, s1_valid_q;
  brc_s1_t          s1_d, s1_q;
  logic             s2_valid_d, s2_valid_q;
  logic             taken_d, taken_q;
  logic             misp_d, misp_q;
  logic             illegal_d, illegal_q;
  logic [TAG_W-1:0] tag_d, tag_q;
  logic             unused_tag_hi;

  brc_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .i_a    (i_rs1_data),
    .i_b    (i_rs2_data),
    .o_eq   (cmp_eq),
    .o_lt_s (cmp_lt_s),
    .o_lt_u (cmp_lt_u)
  );

  // Handshake chain and next state of both stages; flush overrides every advance
  always_comb begin
    s2_adv = ~s2_valid_q | i_ready;
    s1_adv = ~s1_valid_q | s2_adv;
    accept = i_valid & s1_adv;
    res    = br_taken(s1_q.op, s1_q.eq, s1_q.lt_s, s1_q.lt_u);

    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    taken_d    = taken_q;
    misp_d     = misp_q;
    illegal_d  = illegal_q;
    tag_d      = tag_q;

    if (s1_adv) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      s1_d.eq               = cmp_eq;
      s1_d.lt_s             = cmp_lt_s;
      s1_d.lt_u             = cmp_lt_u;
      s1_d.op               = br_op_e'(i_funct3);
      s1_d.pred             = i_pred_taken;
      s1_d.tag              = '0;
      s1_d.tag[TAG_W-1:0]   = i_tag;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        taken_d   = res[1];
        illegal_d = res[0];
        misp_d    = res[1] ^ s1_q.pred;
        tag_d     = s1_q.tag[TAG_W-1:0];
      end
    end

    if (i_flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline registers; reset empties both stages and clears the result fields
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      taken_q    <= 1'b0;
      misp_q     <= 1'b0;
      illegal_q  <= 1'b0;
      tag_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      taken_q    <= taken_d;
      misp_q     <= misp_d;
      illegal_q  <= illegal_d;
      tag_q      <= tag_d;
    end
  end

  assign o_ready       = s1_adv;
  assign o_valid       = s2_valid_q;
  assign o_taken       = taken_q;
  assign o_mispredict  = misp_q;
  assign o_illegal     = illegal_q;
  assign o_tag         = tag_q;
  assign unused_tag_hi = ^s1_q.tag;

`ifdef BRC_PERF_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] br_cnt_d, br_cnt_q;
  logic [CNT_W-1:0] misp_cnt_d, misp_cnt_q;

  // Saturating retire counters; clear wins over a same-cycle increment, flush does not cancel a retire
  always_comb begin
    retire     = s2_valid_q & i_ready;
    br_cnt_d   = br_cnt_q;
    misp_cnt_d = misp_cnt_q;
    if (i_cnt_clr) begin
      br_cnt_d   = '0;
      misp_cnt_d = '0;
    end else if (retire && !illegal_q) begin
      if (!(&br_cnt_q)) begin
        br_cnt_d = br_cnt_q + CNT_W'(1);
      end
      if (misp_q && !(&misp_cnt_q)) begin
        misp_cnt_d = misp_cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt_q   <= '0;
      misp_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      misp_cnt_q <= misp_cnt_d;
    end
  end

  assign o_br_cnt   = br_cnt_q;
  assign o_misp_cnt = misp_cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = i_cnt_clr;
  assign o_br_cnt       = '0;
  assign o_misp_cnt     = '0;
`endif

endmodule

// File: tb/tb_brc_pipe.sv
// tb/tb_brc_pipe.sv - scoreboard bench for brc_pipe (counter checks active under BRC_PERF_CNT_EN)
module tb_brc_pipe;

  localparam int DW = 32;
  localparam int TW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_rs1 = '0;
  logic [DW-1:0] i_rs2 = '0;
  logic [2:0]    i_f3 = '0;
  logic          i_pred = 1'b0;
  logic [TW-1:0] i_tag = '0;
  logic          i_flush = 1'b0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic          o_taken;
  logic          o_misp;
  logic          o_ill;
  logic [TW-1:0] o_tag;
  logic          i_cnt_clr = 1'b0;
  logic [CW-1:0] o_br_cnt;
  logic [CW-1:0] o_misp_cnt;

  typedef struct {
    logic [TW-1:0] tag;
    logic          taken;
    logic          misp;
    logic          ill;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_chk = 0;
  int            n_bad = 0;
  int            n_ret = 0;
  logic          hold_v = 1'b0;
  logic [TW+2:0] hold_f = '0;
  logic [2:0]    f3s[6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
  int unsigned   exp_br = 0;
  int unsigned   exp_misp = 0;

  brc_pipe #(.DATA_W(DW), .TAG_W(TW), .CNT_W(CW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_rs1_data   (i_rs1),
    .i_rs2_data   (i_rs2),
    .i_funct3     (i_f3),
    .i_pred_taken (i_pred),
    .i_tag        (i_tag),
    .i_flush      (i_flush),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_taken      (o_taken),
    .o_mispredict (o_misp),
    .o_illegal    (o_ill),
    .o_tag        (o_tag),
    .i_cnt_clr    (i_cnt_clr),
    .o_br_cnt     (o_br_cnt),
    .o_misp_cnt   (o_misp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [2:0] f3, input logic p, input logic [TW-1:0] t);
    exp_t e;
    e.tag   = t;
    e.ill   = 1'b0;
    e.taken = 1'b0;
    case (f3)
      3'b000:  e.taken = (a == b);
      3'b001:  e.taken = (a != b);
      3'b100:  e.taken = ($signed(a) < $signed(b));
      3'b101:  e.taken = ($signed(a) >= $signed(b));
      3'b110:  e.taken = (a < b);
      3'b111:  e.taken = (a >= b);
      default: e.ill = 1'b1;
    endcase
    e.misp = e.taken ^ p;
    return e;
  endfunction

  // Present one branch and hold it until accepted; expectation queued at the accepting edge
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [2:0] f3, input logic p, input logic [TW-1:0] t);
    bit got;
    got     = 1'b0;
    i_valid = 1'b1;
    i_rs1   = a;
    i_rs2   = b;
    i_f3    = f3;
    i_pred  = p;
    i_tag   = t;
    for (int w = 0; w < 50 && !got; w++) begin
      @(negedge clk);
      if (o_ready) begin
        got = 1'b1;
        sb.push_back(model(a, b, f3, p, t));
      end
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk(name, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: in-order scoreboard compare, stall-hold check, counter model
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v   = 1'b0;
      exp_br   = 0;
      exp_misp = 0;
    end else begin
`ifdef BRC_PERF_CNT_EN
      chk("br_cnt", 64'(o_br_cnt), 64'(exp_br));
      chk("misp_cnt", 64'(o_misp_cnt), 64'(exp_misp));
`endif
      if (hold_v && o_valid) chk("hold", 64'({o_tag, o_taken, o_misp, o_ill}), 64'(hold_f));
      hold_v = 1'b0;
      if (o_valid && !i_ready) begin
        hold_v = 1'b1;
        hold_f = {o_tag, o_taken, o_misp, o_ill};
      end
      mon_e.tag = '0;
      mon_e.ill = 1'b1;
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 64'(o_tag), 64'hDEAD);
        end else begin
          mon_e = sb.pop_front();
          chk("tag", 64'(o_tag), 64'(mon_e.tag));
          chk("taken", 64'(o_taken), 64'(mon_e.taken));
          chk("mispredict", 64'(o_misp), 64'(mon_e.misp));
          chk("illegal", 64'(o_ill), 64'(mon_e.ill));
          n_ret++;
        end
      end
      if (i_cnt_clr) begin
        exp_br   = 0;
        exp_misp = 0;
      end else if (o_valid && i_ready && !mon_e.ill) begin
        if (exp_br < CNT_MAX) exp_br++;
        if (mon_e.misp && exp_misp < CNT_MAX) exp_misp++;
      end
    end
  end

  initial begin
    int ret0;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_taken", 64'(o_taken), 64'd0);
    chk("rst_o_misp", 64'(o_misp), 64'd0);
    chk("rst_o_illegal", 64'(o_ill), 64'd0);
    chk("rst_o_tag", 64'(o_tag), 64'd0);
    chk("rst_cnts", 64'({o_br_cnt, o_misp_cnt}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_o_ready", 64'(o_ready), 64'd1);

    // each funct3 with equal operands, single-shot, exact 2-cycle latency
    for (int i = 0; i < 6; i++) begin
      send(32'd5, 32'd5, f3s[i], 1'b0, TW'(i));
      @(negedge clk);
      chk("latency_c1", 64'(o_valid), 64'd0);
      @(negedge clk);
      chk("latency_c2", 64'(o_valid), 64'd1);
      @(posedge clk);
      #1;
    end

    // boundary operands and reserved encodings, back to back
    send(32'h8000_0000, 32'h7FFF_FFFF, 3'b100, 1'b1, 5'd10);
    send(32'h8000_0000, 32'h7FFF_FFFF, 3'b110, 1'b1, 5'd11);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 1'b0, 5'd12);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100, 1'b0, 5'd13);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b110, 1'b0, 5'd14);
    send(32'h0000_0000, 32'hFFFF_FFFF, 3'b100, 1'b1, 5'd15);
    send(32'h0000_0000, 32'hFFFF_FFFF, 3'b110, 1'b0, 5'd16);
    send(32'h0000_0005, 32'h0000_0005, 3'b010, 1'b1, 5'd17);
    send(32'h0000_0001, 32'h0000_0002, 3'b011, 1'b0, 5'd18);
    drain("drain_boundary");

    // stream of 8 with a 3-cycle downstream stall starting at cycle 4
    ret0 = n_ret;
    fork
      begin
        for (int t = 0; t < 8; t++)
          send($urandom, $urandom, f3s[$urandom_range(0, 5)], 1'($urandom), TW'(t));
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        i_ready = 1'b0;
        @(negedge clk);
        chk("stall_o_ready", 64'(o_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    drain("drain_stall");
    chk("stall_retired", 64'(n_ret - ret0), 64'd8);

    // random operands and funct3 with random backpressure
    fork
      begin
        for (int k = 0; k < 40; k++)
          send(DW'($urandom_range(0, 3)) ^ {DW{1'($urandom)}}, DW'($urandom_range(0, 3)),
               3'($urandom), 1'($urandom), TW'(k));
      end
      begin
        repeat (80) begin
          @(posedge clk);
          #1;
          i_ready = ($urandom_range(0, 9) < 7);
        end
        i_ready = 1'b1;
      end
    join
    drain("drain_random");

    // flush with both stages full and a new branch presented
    i_ready = 1'b0;
    send(32'd1, 32'd1, 3'b000, 1'b0, 5'd20);
    send(32'd1, 32'd2, 3'b000, 1'b0, 5'd21);
    i_valid = 1'b1;
    i_tag   = 5'd22;
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_o_valid", 64'(o_valid), 64'd0);
    chk("flush_o_ready", 64'(o_ready), 64'd1);
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

`ifdef BRC_PERF_CNT_EN
    // saturation then clear coincident with a retire
    for (int k = 0; k < 20; k++) send(32'd1, 32'd1, 3'b000, 1'b0, TW'(k));
    drain("drain_sat");
    chk("br_cnt_sat", 64'(o_br_cnt), 64'hF);
    chk("misp_cnt_sat", 64'(o_misp_cnt), 64'hF);
    i_ready = 1'b0;
    send(32'd1, 32'd1, 3'b000, 1'b0, 5'd3);
    @(posedge clk);
    #1;
    chk("clr_o_valid", 64'(o_valid), 64'd1);
    i_ready   = 1'b1;
    i_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    i_cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_br_cnt", 64'(o_br_cnt), 64'd0);
    chk("clr_misp_cnt", 64'(o_misp_cnt), 64'd0);
    drain("drain_clr");
`else
    i_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    i_cnt_clr = 1'b0;
    chk("cnt_absent", 64'({o_br_cnt, o_misp_cnt}), 64'd0);
`endif

    // asynchronous reset while holding a result
    i_ready = 1'b0;
    send(32'd7, 32'd3, 3'b001, 1'b0, 5'd30);
    send(32'd7, 32'd3, 3'b001, 1'b0, 5'd31);
    chk("pre_rst_o_valid", 64'(o_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_o_valid", 64'(o_valid), 64'd0);
    chk("async_rst_o_tag", 64'(o_tag), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_o_valid", 64'(o_valid), 64'd0);
    chk("post_rst_cnts", 64'({o_br_cnt, o_misp_cnt}), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/brc_pipe.md
Name: brc_pipe

Overview:
- Parametrised, pipelined branch-resolution unit; successor to the single-cycle branch comparator.
- Decodes all six RV32I branch funct3 modes itself and produces a registered taken/not-taken decision, with valid/ready handshakes on both sides.
- Flags mispredictions against a supplied prediction.
- Sits between the execute-stage operand muxes and the PC-redirect logic of the pipelined core.

Parameters:
- DATA_W, 32, operand width in bits (>= 2).
- TAG_W, 5, width of the sideband tag carried with each branch (ROB index / PC tag).
- CNT_W, 32, width of the performance counters (used only with BRC_PERF_CNT_EN).

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  upstream branch valid.
- o_ready  out  1  unit can accept a branch this cycle.
- i_rs1_data  in  DATA_W  operand A.
- i_rs2_data  in  DATA_W  operand B.
- i_funct3  in  3  branch type.
- i_pred_taken  in  1  front-end prediction.
- i_tag  in  TAG_W  sideband tag.
- i_flush  in  1  kill all in-flight branches.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_taken  out  1  branch resolved taken.
- o_mispredict  out  1  o_taken differs from the registered prediction.
- o_illegal  out  1  funct3 was 010 or 011.
- o_tag  out  TAG_W  tag of the result.
- i_cnt_clr  in  1  synchronous counter clear (feature only).
- o_br_cnt  out  CNT_W  retired legal branches (feature only).
- o_misp_cnt  out  CNT_W  retired mispredicted branches (feature only).

Behaviour:
- Reset (async assert, sync release): both stage valids 0, o_valid=0, o_taken=0, o_mispredict=0, o_illegal=0, o_tag=0, counters 0.
- o_ready=1 out of reset.
- Stage 1 (S1), on accept:
  - Registers eq=(A==B); lt_s = signed A<B, computed as sign(A-B) XOR overflow; lt_u = A<B unsigned, computed as ~carry_out of A+~B+1.
  - Also registers funct3, pred, tag.
- Stage 2 (S2) evaluates funct3:
  - 000 BEQ=eq; 001 BNE=~eq.
  - 100 BLT=lt_s; 101 BGE=~lt_s.
  - 110 BLTU=lt_u; 111 BGEU=~lt_u.
  - 010/011: taken=0, illegal=1.
- S2 registers outputs. Latency is exactly 2 cycles from accept to o_valid when unstalled. Throughput is 1 branch per cycle.
- o_mispredict = taken XOR pred, including illegal entries.
- Handshake:
  - Accept when i_valid & o_ready. Output retires when o_valid & i_ready.
  - s2_adv = ~s2_valid | i_ready; s1_adv = ~s1_valid | s2_adv; o_ready = s1_adv (combinational from i_ready; no path from i_valid).
  - While o_valid & ~i_ready, all o_* result fields hold stable.
- Flush:
  - i_flush clears s1_valid and s2_valid on the next edge.
  - A branch presented in the flush cycle is dropped, even if the accept handshake occurs.
  - Flush wins over simultaneous accept and retire; a retire in the flush cycle still counts as retired.
- Boundary values (DATA_W=32):
  - A=0x8000_0000, B=0x7FFF_FFFF: lt_s=1, lt_u=0.
  - A=B=0xFFFF_FFFF: eq=1, lt_s=lt_u=0.
  - A=0, B=0xFFFF_FFFF: lt_s=0, lt_u=1.
- Reset mid-operation: all in-flight entries are lost; o_valid drops immediately, asynchronously.

Optional Feature:
- Macro BRC_PERF_CNT_EN.
- Defined:
  - o_br_cnt increments on each retire with illegal=0.
  - o_misp_cnt increments on each retire with illegal=0 and mispredict=1.
  - Both saturate at all-ones (no wrap).
  - i_cnt_clr zeroes both next edge and wins over a simultaneous increment.
- Undefined: counter registers are absent, o_br_cnt/o_misp_cnt tie to 0, i_cnt_clr is ignored.

Decomposition:
- Package brc_pkg:
  - funct3 enum br_op_e (BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU).
  - Stage-1 struct type (eq, lt_s, lt_u, op, pred, tag).
  - Function br_taken(op, eq, lt_s, lt_u) returning {taken, illegal}.
- One sub-module, brc_cmp: purely combinational, DATA_W-parametrised subtract-based compare producing eq, lt_s, lt_u. It reuses the existing adder for A+~B+1.

Test Plan:
- Each funct3, A=5, B=5 -> BEQ taken, BNE not, BGE/BGEU taken, BLT/BLTU not; o_valid exactly 2 cycles after accept.
- BLT and BLTU with A=0x8000_0000, B=0x7FFF_FFFF -> BLT taken=1, BLTU taken=0; with pred=1 -> mispredict only on BLTU.
- funct3=010, pred=1 -> o_illegal=1, o_taken=0, o_mispredict=1; counters unchanged.
- Back-to-back stream of 8 branches, i_ready low for 3 cycles at cycle 4 -> o_ready drops once both stages are full, outputs held stable, no loss or duplication, tags retire in order 0..7.
- Flush with both stages full plus a new branch presented -> o_valid=0 next cycle, none of the 3 tags ever appear.
- With BRC_PERF_CNT_EN and CNT_W=4: retire 20 mispredicted legal branches -> both counters 0xF (saturated); then i_cnt_clr coincident with a retire -> both 0.
